// File: rtl/mips_ctrl_pkg.sv
// ============================================================================
// Module   : mips_ctrl_pkg
// Purpose  : Shared types and encodings for the multicycle MIPS main control
//            unit: FSM state enum, ALU operation class, opcode/funct values,
//            ALU control codes and datapath mux select encodings.
// Ports    : none (package)
// Options  : MIPS_CTRL_BNE_EN (consumed by mips_multicycle_controller)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_ctrl_pkg;

    // Controller FSM states
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    // Class of ALU operation requested by the FSM. ADD is the all-zero
    // encoding so that states which do not use the ALU default to add.
    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_FUNCT = 2'b10
    } alu_op_t;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct field values (instr[5:0])
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ALU control codes driven to the datapath ALU
    localparam logic [2:0] ALU_CTRL_AND = 3'b000;
    localparam logic [2:0] ALU_CTRL_OR  = 3'b001;
    localparam logic [2:0] ALU_CTRL_ADD = 3'b010;
    localparam logic [2:0] ALU_CTRL_SUB = 3'b110;
    localparam logic [2:0] ALU_CTRL_SLT = 3'b111;

    // ALU source B select
    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

    // Next-PC source select
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage : mips_ctrl_pkg

`default_nettype wire

// File: rtl/alu_decoder.sv
// ============================================================================
// Module   : alu_decoder
// Purpose  : Combinational translation of the FSM's ALU operation class and
//            the instruction funct field into the 3-bit ALU control code.
// Ports    : alu_op      in  ALU operation class (ADD / SUB / FUNCT)
//            funct       in  instr[5:0]
//            alu_control out ALU control code
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_CTRL_ADD;
        case (alu_op)
            ALU_OP_ADD: alu_control = ALU_CTRL_ADD;
            ALU_OP_SUB: alu_control = ALU_CTRL_SUB;
            ALU_OP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALU_CTRL_ADD;
                    FUNCT_SUB: alu_control = ALU_CTRL_SUB;
                    FUNCT_AND: alu_control = ALU_CTRL_AND;
                    FUNCT_OR:  alu_control = ALU_CTRL_OR;
                    FUNCT_SLT: alu_control = ALU_CTRL_SLT;
                    // Unsupported R-type functions fall back to add
                    default:   alu_control = ALU_CTRL_ADD;
                endcase
            end
            default: alu_control = ALU_CTRL_ADD;
        endcase
    end

endmodule : alu_decoder

`default_nettype wire

// File: rtl/mips_multicycle_controller.sv
// ============================================================================
// Module   : mips_multicycle_controller
// Purpose  : Main control unit of the multicycle MIPS core. A Moore FSM walks
//            each instruction through fetch / decode / execute / memory /
//            writeback and drives every datapath select, write enable and
//            ALU control code. Also counts retired instructions.
// Ports    : clk          in  clock, rising edge
//            reset_n      in  asynchronous active-low reset
//            opcode       in  instr[31:26]
//            funct        in  instr[5:0]
//            zero         in  ALU zero flag
//            pc_en        out PC enable = pc_write | (branch & taken)
//            ir_write     out instruction register enable
//            mem_write    out memory write enable
//            reg_write    out register file write enable
//            i_or_d       out memory address select (0 PC, 1 ALUOut)
//            reg_dst      out write register select (0 rt, 1 rd)
//            mem_to_reg   out writeback select (0 ALUOut, 1 Data)
//            alu_src_a    out ALU A select (0 PC, 1 A)
//            alu_src_b    out ALU B select (B / 4 / SignImm / SignImm<<2)
//            pc_src       out next-PC select (ALUResult / ALUOut / jump)
//            alu_control  out ALU control code
//            illegal_op   out one-cycle pulse in DECODE on unknown opcode
//            instr_count  out instructions retired since reset
// Options  : MIPS_CTRL_BNE_EN - when defined, bne (opcode 000101) is executed
//            through the BRANCH state with inverted zero sense; otherwise it
//            is treated as an illegal opcode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [5:0]             opcode,
    input  logic [5:0]             funct,
    input  logic                   zero,
    output logic                   pc_en,
    output logic                   ir_write,
    output logic                   mem_write,
    output logic                   reg_write,
    output logic                   i_or_d,
    output logic                   reg_dst,
    output logic                   mem_to_reg,
    output logic                   alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [1:0]             pc_src,
    output logic [2:0]             alu_control,
    output logic                   illegal_op,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_t  state;
    state_t  next_state;
    alu_op_t alu_op;

    // Raw FSM decode of the write enables, before reset gating
    logic pc_write;
    logic branch;
    logic ir_write_fsm;
    logic mem_write_fsm;
    logic reg_write_fsm;
    logic illegal_fsm;
    logic branch_taken;
    logic retire;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and Moore output decode
    // ------------------------------------------------------------------
    always_comb begin
        next_state    = state;
        pc_write      = 1'b0;
        branch        = 1'b0;
        ir_write_fsm  = 1'b0;
        mem_write_fsm = 1'b0;
        reg_write_fsm = 1'b0;
        illegal_fsm   = 1'b0;
        i_or_d        = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_REG;
        pc_src        = PC_SRC_ALU;
        alu_op        = ALU_OP_ADD;

        case (state)
            S_FETCH: begin
                ir_write_fsm = 1'b1;
                pc_write     = 1'b1;
                alu_src_b    = SRC_B_FOUR;
                alu_op       = ALU_OP_ADD;
                next_state   = S_DECODE;
            end
            S_DECODE: begin
                // Precompute the branch target while the opcode is decoded
                alu_src_b = SRC_B_IMM_SH;
                alu_op    = ALU_OP_ADD;
                case (opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXECUTE;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_ADDI:      next_state = S_ADDIEXEC;
                    OP_J:         next_state = S_JUMP;
`ifdef MIPS_CTRL_BNE_EN
                    OP_BNE:       next_state = S_BRANCH;
`else
                    OP_BNE: begin
                        illegal_fsm = 1'b1;
                        next_state  = S_FETCH;
                    end
`endif
                    default: begin
                        illegal_fsm = 1'b1;
                        next_state  = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRC_B_IMM;
                alu_op     = ALU_OP_ADD;
                // Only lw and sw reach this state; anything not lw is a store
                next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                i_or_d     = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write_fsm = 1'b1;
                mem_to_reg    = 1'b1;
                next_state    = S_FETCH;
            end
            S_MEMWR: begin
                i_or_d        = 1'b1;
                mem_write_fsm = 1'b1;
                next_state    = S_FETCH;
            end
            S_EXECUTE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRC_B_REG;
                alu_op     = ALU_OP_FUNCT;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_fsm = 1'b1;
                reg_dst       = 1'b1;
                next_state    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_OP_SUB;
                pc_src     = PC_SRC_ALUOUT;
                branch     = 1'b1;
                next_state = S_FETCH;
            end
            S_ADDIEXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRC_B_IMM;
                alu_op     = ALU_OP_ADD;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_fsm = 1'b1;
                next_state    = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = PC_SRC_JUMP;
                pc_write   = 1'b1;
                next_state = S_FETCH;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Branch sense
    // ------------------------------------------------------------------
`ifdef MIPS_CTRL_BNE_EN
    // Remembers whether the instruction now in BRANCH is a bne
    logic branch_ne;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            branch_ne <= 1'b0;
        end else if (state == S_DECODE) begin
            branch_ne <= (opcode == OP_BNE);
        end
    end

    assign branch_taken = branch_ne ? ~zero : zero;
`else
    assign branch_taken = zero;
`endif

    // ------------------------------------------------------------------
    // Write enables are held low for as long as reset is asserted; the
    // selects keep their FETCH values since the state is forced to FETCH.
    // ------------------------------------------------------------------
    assign pc_en      = reset_n & (pc_write | (branch & branch_taken));
    assign ir_write   = reset_n & ir_write_fsm;
    assign mem_write  = reset_n & mem_write_fsm;
    assign reg_write  = reset_n & reg_write_fsm;
    assign illegal_op = reset_n & illegal_fsm;

    // ------------------------------------------------------------------
    // ALU control decode
    // ------------------------------------------------------------------
    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (funct),
        .alu_control (alu_control)
    );

    // ------------------------------------------------------------------
    // Retired-instruction counter. Only terminal states retire; the
    // illegal DECODE->FETCH path is deliberately not counted.
    // ------------------------------------------------------------------
    always_comb begin
        retire = 1'b0;
        case (state)
            S_MEMWB, S_MEMWR, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: retire = 1'b1;
            default: retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_count <= '0;
        end else if (retire) begin
            instr_count <= instr_count + COUNT_ONE;
        end
    end

endmodule : mips_multicycle_controller

`default_nettype wire

// File: tb/tb_mips_multicycle_controller.sv
// ============================================================================
// Module   : tb_mips_multicycle_controller
// Purpose  : Directed self-checking bench for mips_multicycle_controller.
//            Outputs are packed into a 16-bit bundle
//            {pc_en, ir_write, mem_write, reg_write, i_or_d, reg_dst,
//             mem_to_reg, alu_src_a, alu_src_b[1:0], pc_src[1:0],
//             alu_control[2:0], illegal_op}
//            and compared per cycle against hand-computed constants.
// Options  : MIPS_CTRL_BNE_EN selects the bne expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_multicycle_controller;

    // Hand-computed expected output bundles per state
    localparam logic [15:0] E_RESET     = 16'h0044;
    localparam logic [15:0] E_FETCH     = 16'hC044;
    localparam logic [15:0] E_DECODE    = 16'h00C4;
    localparam logic [15:0] E_DECODE_IL = 16'h00C5;
    localparam logic [15:0] E_MEMADR    = 16'h0184;
    localparam logic [15:0] E_MEMRD     = 16'h0804;
    localparam logic [15:0] E_MEMWB     = 16'h1204;
    localparam logic [15:0] E_MEMWR     = 16'h2804;
    localparam logic [15:0] E_ALUWB     = 16'h1404;
    localparam logic [15:0] E_ADDIWB    = 16'h1004;
    localparam logic [15:0] E_BR_TAKEN  = 16'h811C;
    localparam logic [15:0] E_BR_NOT    = 16'h011C;
    localparam logic [15:0] E_JUMP      = 16'h8024;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        pc_en, ir_write, mem_write, reg_write, i_or_d, reg_dst;
    logic        mem_to_reg, alu_src_a, illegal_op;
    logic [1:0]  alu_src_b, pc_src;
    logic [2:0]  alu_control;
    logic [31:0] instr_count;
    logic [15:0] obs;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;

    logic [5:0]  fn_tab [5];
    logic [15:0] ex_tab [5];

    always #5 clk = ~clk;

    assign obs = {pc_en, ir_write, mem_write, reg_write, i_or_d, reg_dst,
                  mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_control, illegal_op};

    mips_multicycle_controller #(.COUNT_WIDTH(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .pc_en       (pc_en),
        .ir_write    (ir_write),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .i_or_d      (i_or_d),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .pc_src      (pc_src),
        .alu_control (alu_control),
        .illegal_op  (illegal_op),
        .instr_count (instr_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] actual,
                            input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Check the current cycle's bundle, then move to the next sample point
    task automatic step(input string tag, input logic [15:0] expected);
        check_eq(tag, {16'h0, obs}, {16'h0, expected});
        @(negedge clk);
        #1;
    endtask

    task automatic start_instr(input logic [5:0] op, input logic [5:0] fn,
                               input logic z);
        opcode = op;
        funct  = fn;
        zero   = z;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fn_tab[0] = 6'b100000; ex_tab[0] = 16'h0104;
        fn_tab[1] = 6'b100100; ex_tab[1] = 16'h0100;
        fn_tab[2] = 6'b100101; ex_tab[2] = 16'h0102;
        fn_tab[3] = 6'b101010; ex_tab[3] = 16'h010E;
        fn_tab[4] = 6'b000000; ex_tab[4] = 16'h0104;

        reset_n = 1'b0;
        opcode  = 6'b100011;
        funct   = 6'b000000;
        zero    = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_eq("reset_bundle", {16'h0, obs}, {16'h0, E_RESET});
        check_eq("reset_count", instr_count, 32'd0);

        @(negedge clk);
        reset_n = 1'b1;
        #1;

        // lw
        start_instr(6'b100011, 6'b000000, 1'b0);
        step("lw_fetch", E_FETCH);
        step("lw_decode", E_DECODE);
        step("lw_memadr", E_MEMADR);
        check_eq("lw_count_mid", instr_count, 32'd0);
        step("lw_memrd", E_MEMRD);
        step("lw_memwb", E_MEMWB);
        exp_count++;
        check_eq("lw_count", instr_count, exp_count);

        // R-type sub
        start_instr(6'b000000, 6'b100010, 1'b0);
        step("sub_fetch", E_FETCH);
        step("sub_decode", E_DECODE);
        step("sub_execute", 16'h010C);
        step("sub_aluwb", E_ALUWB);
        exp_count++;
        check_eq("sub_count", instr_count, exp_count);

        // Remaining R-type functions, including an unsupported one
        for (int i = 0; i < 5; i++) begin
            start_instr(6'b000000, fn_tab[i], 1'b0);
            step("rt_fetch", E_FETCH);
            step("rt_decode", E_DECODE);
            step("rt_execute", ex_tab[i]);
            step("rt_aluwb", E_ALUWB);
            exp_count++;
        end
        check_eq("rt_count", instr_count, exp_count);

        // addi
        start_instr(6'b001000, 6'b000000, 1'b0);
        step("addi_fetch", E_FETCH);
        step("addi_decode", E_DECODE);
        step("addi_exec", E_MEMADR);
        step("addi_wb", E_ADDIWB);
        exp_count++;

        // beq taken / not taken
        start_instr(6'b000100, 6'b000000, 1'b1);
        step("beq_t_fetch", E_FETCH);
        step("beq_t_decode", E_DECODE);
        step("beq_t_branch", E_BR_TAKEN);
        exp_count++;
        start_instr(6'b000100, 6'b000000, 1'b0);
        step("beq_n_fetch", E_FETCH);
        step("beq_n_decode", E_DECODE);
        step("beq_n_branch", E_BR_NOT);
        exp_count++;
        check_eq("beq_count", instr_count, exp_count);

        // j then sw
        start_instr(6'b000010, 6'b000000, 1'b0);
        step("j_fetch", E_FETCH);
        step("j_decode", E_DECODE);
        step("j_jump", E_JUMP);
        exp_count++;
        start_instr(6'b101011, 6'b000000, 1'b0);
        step("sw_fetch", E_FETCH);
        step("sw_decode", E_DECODE);
        step("sw_memadr", E_MEMADR);
        step("sw_memwr", E_MEMWR);
        exp_count++;
        check_eq("sw_count", instr_count, exp_count);

        // Illegal opcode: pulse in DECODE, back to FETCH, not counted
        start_instr(6'b111111, 6'b000000, 1'b0);
        step("ill_fetch", E_FETCH);
        step("ill_decode", E_DECODE_IL);
        check_eq("ill_back_fetch", {16'h0, obs}, {16'h0, E_FETCH});
        check_eq("ill_count", instr_count, exp_count);

        // bne
`ifdef MIPS_CTRL_BNE_EN
        start_instr(6'b000101, 6'b000000, 1'b0);
        step("bne_t_fetch", E_FETCH);
        step("bne_t_decode", E_DECODE);
        step("bne_t_branch", E_BR_TAKEN);
        exp_count++;
        start_instr(6'b000101, 6'b000000, 1'b1);
        step("bne_n_fetch", E_FETCH);
        step("bne_n_decode", E_DECODE);
        step("bne_n_branch", E_BR_NOT);
        exp_count++;
`else
        start_instr(6'b000101, 6'b000000, 1'b0);
        step("bne_fetch", E_FETCH);
        step("bne_decode_ill", E_DECODE_IL);
`endif
        check_eq("bne_count", instr_count, exp_count);

        // A beq after bne must use normal zero sense again
        start_instr(6'b000100, 6'b000000, 1'b0);
        step("beq2_fetch", E_FETCH);
        step("beq2_decode", E_DECODE);
        step("beq2_branch", E_BR_NOT);
        exp_count++;
        check_eq("beq2_count", instr_count, exp_count);

        // Reset during MEMRD of a lw
        start_instr(6'b100011, 6'b000000, 1'b0);
        step("rst_lw_fetch", E_FETCH);
        step("rst_lw_decode", E_DECODE);
        step("rst_lw_memadr", E_MEMADR);
        check_eq("rst_lw_memrd", {16'h0, obs}, {16'h0, E_MEMRD});
        reset_n = 1'b0;
        #1;
        check_eq("rst_async_bundle", {16'h0, obs}, {16'h0, E_RESET});
        check_eq("rst_async_count", instr_count, 32'd0);
        exp_count = 0;
        @(negedge clk);
        #1;
        check_eq("rst_hold_bundle", {16'h0, obs}, {16'h0, E_RESET});
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        step("post_rst_fetch", E_FETCH);
        check_eq("post_rst_count", instr_count, 32'd0);
        step("post_rst_decode", E_DECODE);
        step("post_rst_memadr", E_MEMADR);
        step("post_rst_memrd", E_MEMRD);
        step("post_rst_memwb", E_MEMWB);
        exp_count++;
        check_eq("post_rst_count2", instr_count, exp_count);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mips_multicycle_controller

`default_nettype wire
